// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path and its auto-baud controller.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, CALC, ERR} autobaud_state_t;
   typedef enum logic [1:0] {E_TIMEOUT, E_PATTERN, E_RANGE} autobaud_err_t;

   // Truncating divisor: sys_clk cycles per 1/16 bit at the given baud.
   function automatic logic [15:0] calc_div(input int unsigned freq, input int unsigned baud);
      return 16'(freq / (OVERSAMPLE * baud));
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx line plus a one-cycle falling-edge pulse.
module uart_rx_sync (
   input  logic sys_clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync,
   output logic fall
);

   logic meta, sync_d0, sync_d1;

   // Reset to the idle-high level so no spurious edge appears when reset drops.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         meta    <= 1'b1;
         sync_d0 <= 1'b1;
         sync_d1 <= 1'b1;
      end else begin
         meta    <= rx;
         sync_d0 <= meta;
         sync_d1 <= sync_d0;
      end
   end

   assign rx_sync = sync_d0;
   assign fall    = sync_d1 & ~sync_d0;

endmodule

// File: rtl/uart_rx_autobaud_ctrl.sv
// Auto-baud controller: times one 0x55 sync character on rx and derives the
// receiver's 16x oversampling divisor, holding the receiver off while it measures.
module uart_rx_autobaud_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned pSYS_CLK_FREQ = 100000000,
   parameter int unsigned pDEFAULT_BAUD = 9600,
   parameter int          pCNT_W        = 22,
   parameter int          pIDLE_CYC     = 2048,
   parameter int          pMIN_DIV      = 4
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        baud_start,
   input  logic        baud_abort,
   output logic        busy,
   output logic        rx_enable,
   output logic [15:0] div_out,
   output logic        div_valid,
   output logic        err_timeout,
   output logic        err_pattern,
   output logic        err_range
);

   localparam logic [15:0]        DEF_DIV   = calc_div(pSYS_CLK_FREQ, pDEFAULT_BAUD);
   localparam int                 IDLE_W    = $clog2(pIDLE_CYC + 1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(pIDLE_CYC - 1);
   localparam logic [pCNT_W-1:0]  CNT_MAX   = '1;

   autobaud_state_t   state, state_nxt;
   autobaud_err_t     err_sel, err_sel_nxt;
   logic              rx_sync, fall, abort_hit, interval_ok, div_ok;
   logic [pCNT_W-1:0] cnt, last, ref_int, interval, ref_lo;
   logic [pCNT_W:0]   ref_hi, div_sum;
   logic [31:0]       div_calc;
   logic [2:0]        edges;
   logic [IDLE_W-1:0] idle_cnt;

   uart_rx_sync u_sync (
      .sys_clk (sys_clk),
      .rst     (rst),
      .rx      (rx),
      .rx_sync (rx_sync),
      .fall    (fall)
   );

   // Edges of 0x55 are 2*Tbit apart; allow +/-25% of the first measured gap.
   assign interval    = cnt - last;
   assign ref_lo      = ref_int - (ref_int >> 2);
   assign ref_hi      = {1'b0, ref_int} + {3'b000, ref_int[pCNT_W-1:2]};
   assign interval_ok = (interval >= ref_lo) && ({1'b0, interval} <= ref_hi);

   // cnt spans 8 bit times; /128 = (8*Tbit)/(8*16), rounded to nearest.
   assign div_sum   = {1'b0, cnt} + (pCNT_W + 1)'(64);
   assign div_calc  = 32'(div_sum >> 7);
   assign div_ok    = (div_calc >= 32'(pMIN_DIV)) && (div_calc <= 32'd65535);
   assign abort_hit = baud_abort && (state != IDLE);

   always_comb begin
      state_nxt   = state;
      err_sel_nxt = err_sel;
      case (state)
         IDLE:       if (baud_start) state_nxt = WAIT_IDLE;
         WAIT_IDLE:  if (rx_sync && idle_cnt == IDLE_LAST) state_nxt = WAIT_START;
         WAIT_START: if (fall) state_nxt = MEASURE;
         MEASURE: begin
            if (cnt == CNT_MAX) begin
               state_nxt   = ERR;
               err_sel_nxt = E_TIMEOUT;
            end else if (fall && edges >= 3'd2 && !interval_ok) begin
               state_nxt   = ERR;
               err_sel_nxt = E_PATTERN;
            end else if (fall && edges == 3'd4) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            state_nxt = div_ok ? IDLE : ERR;
            if (!div_ok) err_sel_nxt = E_RANGE;
         end
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_hit) state_nxt = IDLE;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= IDLE;
         err_sel     <= E_TIMEOUT;
         busy        <= 1'b0;
         rx_enable   <= 1'b1;
         div_out     <= DEF_DIV;
         div_valid   <= 1'b0;
         err_timeout <= 1'b0;
         err_pattern <= 1'b0;
         err_range   <= 1'b0;
         cnt         <= '0;
         last        <= '0;
         ref_int     <= '0;
         edges       <= '0;
         idle_cnt    <= '0;
      end else begin
         state     <= state_nxt;
         err_sel   <= err_sel_nxt;
         div_valid <= 1'b0;
         if (!abort_hit) begin
            case (state)
               IDLE: if (baud_start) begin
                  err_timeout <= 1'b0;
                  err_pattern <= 1'b0;
                  err_range   <= 1'b0;
                  busy        <= 1'b1;
                  rx_enable   <= 1'b0;
                  idle_cnt    <= '0;
               end
               WAIT_IDLE:  idle_cnt <= rx_sync ? idle_cnt + 1'b1 : '0;
               WAIT_START: if (fall) begin
                  cnt   <= '0;
                  last  <= '0;
                  edges <= 3'd1;
               end
               MEASURE: begin
                  // Hold cnt on edge 5 so CALC sees exactly the edge-1..edge-5 span.
                  if (cnt != CNT_MAX && !(fall && edges == 3'd4)) cnt <= cnt + 1'b1;
                  if (fall) begin
                     last  <= cnt;
                     edges <= edges + 3'd1;
                     if (edges == 3'd1) ref_int <= interval;
                  end
               end
               CALC: if (div_ok) begin
                  div_out   <= div_calc[15:0];
                  div_valid <= 1'b1;
               end
               ERR: begin
                  case (err_sel)
                     E_TIMEOUT: err_timeout <= 1'b1;
                     E_PATTERN: err_pattern <= 1'b1;
                     default:   err_range   <= 1'b1;
                  endcase
               end
               default: ;
            endcase
         end
         if (state != IDLE && state_nxt == IDLE) begin
            busy      <= 1'b0;
            rx_enable <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_autobaud_ctrl.sv
// Scoreboard bench for uart_rx_autobaud_ctrl, run with a 10 MHz sys_clk and a
// 14-bit measurement counter so every scenario, including timeout, stays short.
`timescale 1ns/1ps
module tb_uart_rx_autobaud_ctrl;

   localparam int          CLK_NS  = 100;
   localparam int unsigned FREQ    = 10_000_000;
   localparam int          CNT_W   = 14;
   localparam logic [15:0] DEF_DIV = 16'd65;
   localparam int T9600 = 104167, T19200 = 52083, T115200 = 8681, T3M = 333;

   typedef struct packed {
      logic        dv;
      logic [15:0] div;
      logic        et;
      logic        ep;
      logic        er;
   } res_t;

   logic sys_clk = 1'b0, rst = 1'b1, rx = 1'b1, baud_start = 1'b0, baud_abort = 1'b0;
   logic busy, rx_enable, div_valid, err_timeout, err_pattern, err_range;
   logic [15:0] div_out;

   res_t        sb[$];
   res_t        r_obs, e;
   logic [1:0]  bs_obs, bs2_obs;
   int          dvs_obs, cyc_obs;
   bit          to_obs;
   logic [15:0] cur_div;
   int          checks = 0, errors = 0;

   uart_rx_autobaud_ctrl #(
      .pSYS_CLK_FREQ (FREQ),
      .pDEFAULT_BAUD (9600),
      .pCNT_W        (CNT_W),
      .pIDLE_CYC     (2048),
      .pMIN_DIV      (4)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .rx          (rx),
      .baud_start  (baud_start),
      .baud_abort  (baud_abort),
      .busy        (busy),
      .rx_enable   (rx_enable),
      .div_out     (div_out),
      .div_valid   (div_valid),
      .err_timeout (err_timeout),
      .err_pattern (err_pattern),
      .err_range   (err_range)
   );

   always #(CLK_NS/2) sys_clk = ~sys_clk;

   // round(8*Tbit / (128 * clock period))
   function automatic logic [15:0] model_div(input int tbit);
      return 16'((8 * tbit + 64 * CLK_NS) / (128 * CLK_NS));
   endfunction

   function automatic res_t snap();
      return {div_valid, div_out, err_timeout, err_pattern, err_range};
   endfunction

   task automatic send_frame(input logic [7:0] b, input int tbit);
      rx = 1'b0; #(tbit);
      for (int i = 0; i < 8; i++) begin rx = b[i]; #(tbit); end
      rx = 1'b1; #(tbit);
   endtask

   task automatic pulse_start(input bit with_abort);
      @(negedge sys_clk); baud_start = 1'b1; baud_abort = with_abort;
      @(negedge sys_clk); baud_start = 1'b0; baud_abort = 1'b0;
   endtask

   // Waits (bounded) for busy to fall and snapshots outputs on that cycle.
   task automatic wait_done(input int budget);
      logic prev;
      bit   seen;
      prev = busy; seen = 0; dvs_obs = 0; cyc_obs = 0; r_obs = '0;
      while (!seen && cyc_obs < budget) begin
         @(negedge sys_clk); cyc_obs++;
         if (div_valid) dvs_obs++;
         if (prev && !busy) begin seen = 1; r_obs = snap(); end
         prev = busy;
      end
      to_obs = !seen;
      repeat (4) begin @(negedge sys_clk); if (div_valid) dvs_obs++; end
   endtask

   task automatic do_measure(input logic [7:0] b0, input logic [7:0] b1, input bit two, input int tbit);
      pulse_start(1'b0);
      bs_obs = {busy, rx_enable};
      repeat (2100) @(negedge sys_clk);
      fork
         begin send_frame(b0, tbit); if (two) send_frame(b1, tbit); end
         wait_done(40000);
      join
   endtask

   task automatic test_reset();
      rst = 1'b1; repeat (3) @(negedge sys_clk); rst = 1'b0;
      checks++; if (snap() !== res_t'{dv:1'b0, div:DEF_DIV, et:1'b0, ep:1'b0, er:1'b0}) begin
         errors++; $display("FAIL reset_outputs got %h exp %h", snap(), {1'b0, DEF_DIV, 3'b000}); end
      checks++; if ({busy, rx_enable} !== 2'b01) begin
         errors++; $display("FAIL reset_busy_en got %b exp 01", {busy, rx_enable}); end
      dvs_obs = 0;
      repeat (20) begin @(negedge sys_clk); if (div_valid || busy) dvs_obs++; end
      checks++; if (dvs_obs !== 0) begin
         errors++; $display("FAIL reset_quiet got %0d active cycles exp 0", dvs_obs); end
      cur_div = DEF_DIV;
   endtask

   task automatic test_measure(input string name, input int tbit);
      sb.push_back(res_t'{dv:1'b1, div:model_div(tbit), et:1'b0, ep:1'b0, er:1'b0});
      do_measure(8'h55, 8'h00, 1'b0, tbit);
      e = sb.pop_front();
      checks++; if (bs_obs !== 2'b10) begin
         errors++; $display("FAIL %s_busy_rise got %b exp 10", name, bs_obs); end
      checks++; if (to_obs !== 1'b0) begin
         errors++; $display("FAIL %s_done got timeout exp busy fall", name); end
      checks++; if (r_obs !== e) begin
         errors++; $display("FAIL %s_result got %h exp %h", name, r_obs, e); end
      checks++; if (dvs_obs !== 1) begin
         errors++; $display("FAIL %s_dv_count got %0d exp 1", name, dvs_obs); end
      cur_div = e.div;
   endtask

   task automatic test_back_to_back();
      test_measure("b2b_115200", T115200);
      test_measure("b2b_19200", T19200);
   endtask

   task automatic test_timeout();
      sb.push_back(res_t'{dv:1'b0, div:cur_div, et:1'b1, ep:1'b0, er:1'b0});
      pulse_start(1'b0);
      repeat (2100) @(negedge sys_clk);
      rx = 1'b0;
      wait_done(20000);
      rx = 1'b1;
      e = sb.pop_front();
      checks++; if (to_obs !== 1'b0) begin
         errors++; $display("FAIL timeout_done got no busy fall exp busy fall"); end
      checks++; if (r_obs !== e) begin
         errors++; $display("FAIL timeout_result got %h exp %h", r_obs, e); end
      checks++; if (cyc_obs < (2**CNT_W - 1) || cyc_obs > (2**CNT_W + 16)) begin
         errors++; $display("FAIL timeout_cycles got %0d exp about %0d", cyc_obs, 2**CNT_W); end
   endtask

   task automatic test_errors();
      // 0x0F then 0x55: edge 4 arrives 2*Tbit after a 5*Tbit reference gap.
      sb.push_back(res_t'{dv:1'b0, div:cur_div, et:1'b0, ep:1'b1, er:1'b0});
      do_measure(8'h0F, 8'h55, 1'b1, T19200);
      e = sb.pop_front();
      checks++; if (to_obs !== 1'b0 || r_obs !== e || dvs_obs !== 0) begin
         errors++; $display("FAIL pattern_result got %h dv %0d exp %h dv 0", r_obs, dvs_obs, e); end
      sb.push_back(res_t'{dv:1'b0, div:cur_div, et:1'b0, ep:1'b0, er:1'b1});
      do_measure(8'h55, 8'h00, 1'b0, T3M);
      e = sb.pop_front();
      checks++; if (to_obs !== 1'b0 || r_obs !== e || dvs_obs !== 0) begin
         errors++; $display("FAIL range_result got %h dv %0d exp %h dv 0", r_obs, dvs_obs, e); end
   endtask

   task automatic test_start_while_busy();
      sb.push_back(res_t'{dv:1'b1, div:model_div(T115200), et:1'b0, ep:1'b0, er:1'b0});
      pulse_start(1'b1);
      checks++; if ({busy, rx_enable} !== 2'b10) begin
         errors++; $display("FAIL start_with_abort got %b exp 10", {busy, rx_enable}); end
      repeat (2100) @(negedge sys_clk);
      fork
         send_frame(8'h55, T115200);
         begin
            #(3 * T115200);
            @(negedge sys_clk); baud_start = 1'b1;
            @(negedge sys_clk); baud_start = 1'b0;
            bs2_obs = {busy, rx_enable};
         end
         wait_done(40000);
      join
      e = sb.pop_front();
      checks++; if (bs2_obs !== 2'b10) begin
         errors++; $display("FAIL restart_ignored_busy got %b exp 10", bs2_obs); end
      checks++; if (to_obs !== 1'b0 || r_obs !== e || dvs_obs !== 1) begin
         errors++; $display("FAIL restart_result got %h dv %0d exp %h dv 1", r_obs, dvs_obs, e); end
      cur_div = e.div;
   endtask

   task automatic test_abort();
      sb.push_back(res_t'{dv:1'b0, div:cur_div, et:1'b0, ep:1'b0, er:1'b0});
      pulse_start(1'b0);
      repeat (2100) @(negedge sys_clk);
      fork
         send_frame(8'h55, T19200);
         begin
            #(T19200 * 9 / 2);
            @(negedge sys_clk); baud_abort = 1'b1;
            @(negedge sys_clk); baud_abort = 1'b0;
            bs_obs = {busy, rx_enable};
            r_obs  = snap();
            dvs_obs = 0;
            repeat (3000) begin
               @(negedge sys_clk);
               if (div_valid || err_timeout || err_pattern || err_range || busy) dvs_obs++;
            end
         end
      join
      e = sb.pop_front();
      checks++; if (bs_obs !== 2'b01) begin
         errors++; $display("FAIL abort_release got %b exp 01", bs_obs); end
      checks++; if (r_obs !== e || dvs_obs !== 0) begin
         errors++; $display("FAIL abort_quiet got %h active %0d exp %h active 0", r_obs, dvs_obs, e); end
   endtask

   task automatic test_reset_mid();
      pulse_start(1'b0);
      repeat (2100) @(negedge sys_clk);
      fork
         send_frame(8'h55, T19200);
         begin
            #(3 * T19200);
            @(negedge sys_clk); rst = 1'b1;
            repeat (3) @(negedge sys_clk); rst = 1'b0;
            r_obs  = snap();
            bs_obs = {busy, rx_enable};
         end
      join
      checks++; if (r_obs !== res_t'{dv:1'b0, div:DEF_DIV, et:1'b0, ep:1'b0, er:1'b0} || bs_obs !== 2'b01) begin
         errors++; $display("FAIL reset_mid got %h %b exp %h 01", r_obs, bs_obs, {1'b0, DEF_DIV, 3'b000}); end
      cur_div = DEF_DIV;
   endtask

   initial begin
      test_reset();
      test_measure("9600", T9600);
      test_back_to_back();
      test_timeout();
      test_errors();
      test_start_while_busy();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(64'd50_000_000);
      $display("FAIL watchdog got no finish exp finish within 50 ms");
      $fatal(1);
   end

endmodule
